// File: rtl/mpc_wr_arbiter.sv
// -----------------------------------------------------------------------------
// mpc_wr_arbiter
//
// Packet-granular round-robin arbiter in front of the mpcache write interface.
// NUM_PORTS ingress requesters share one cache write path. A grant is held
// from the first beat to the end-of-packet beat. New grants are gated by
// almost_full, and individual beats are stalled by full. A beat-count
// watchdog truncates packets that reach MAX_BEATS.
//
// Ports
//   clk_in       single clock, rising edge
//   rst_in       asynchronous, active-high reset
//   req          per-port "complete packet ready"
//   in_sop       per-port start-of-packet qualifier
//   in_eop       per-port end-of-packet qualifier
//   in_vld       per-port beat valid
//   in_data      per-port beat data, port p at [p*DATA_W +: DATA_W]
//   gnt          one-hot (or zero) grant; a beat is consumed on
//                gnt[p] & in_vld[p] & !full
//   full         cache full, stalls beat acceptance
//   almost_full  cache almost full, blocks new grants only
//   wr_sop       cache write start-of-packet
//   wr_eop       cache write end-of-packet
//   wr_vld       cache write valid
//   wr_data      cache write data
//   wr_port      source port of the current beat
//   err_len      one-cycle pulse when the watchdog truncates a packet
//   err_sop      one-cycle pulse when a grant's first beat lacked in_sop
// -----------------------------------------------------------------------------
module mpc_wr_arbiter #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 32,
  parameter int PORT_W    = 4,
  parameter int MAX_BEATS = 64
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        in_sop,
  input  logic [NUM_PORTS-1:0]        in_eop,
  input  logic [NUM_PORTS-1:0]        in_vld,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        gnt,
  input  logic                        full,
  input  logic                        almost_full,
  output logic                        wr_sop,
  output logic                        wr_eop,
  output logic                        wr_vld,
  output logic [DATA_W-1:0]           wr_data,
  output logic [PORT_W-1:0]           wr_port,
  output logic                        err_len,
  output logic                        err_sop
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [PORT_W-1:0]     port_q, port_d;
  logic [PORT_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic                  wr_sop_q, wr_eop_q, wr_vld_q, err_len_q, err_sop_q;
  logic [DATA_W-1:0]     wr_data_q;
  logic [PORT_W-1:0]     wr_port_q;

  logic                  accept, first_beat, force_eop, eop_beat;
  logic [PORT_W-1:0]     next_ptr, arb_ptr, arb_sel;
  logic                  arb_found;
  logic [DATA_W-1:0]     port_data [NUM_PORTS];

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_data[p] = in_data[p*DATA_W +: DATA_W];
    end
  end

  assign accept     = (state_q == ST_XFER) && in_vld[port_q] && !full;
  assign first_beat = (beat_cnt_q == '0);
  assign force_eop  = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  assign eop_beat   = in_eop[port_q] || force_eop;
  assign next_ptr   = PORT_W'((int'(port_q) + 1) % NUM_PORTS);

  // On an accepted eop beat the pointer update and the next arbitration
  // happen in the same cycle, so the search must already start at port+1.
  assign arb_ptr = (accept && eop_beat) ? next_ptr : rr_ptr_q;

  // Round-robin search: first requester at or above arb_ptr, with wrap.
  always_comb begin
    logic [PORT_W-1:0] cand;
    arb_found = 1'b0;
    arb_sel   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PORT_W'((int'(arb_ptr) + i) % NUM_PORTS);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_sel   = cand;
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    port_d     = port_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_found && !almost_full) begin
          gnt_d   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << arb_sel;
          port_d  = arb_sel;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          if (eop_beat) begin
            rr_ptr_d   = next_ptr;
            beat_cnt_d = '0;
            // almost_full is only looked at here and in IDLE, never mid-packet.
            if (arb_found && !almost_full) begin
              gnt_d  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << arb_sel;
              port_d = arb_sel;
            end else begin
              gnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  // NOTE: the data-path registers are reset as well, because every output,
  // wr_data and wr_port included, must read 0 while reset is asserted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      port_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      wr_sop_q   <= 1'b0;
      wr_eop_q   <= 1'b0;
      wr_vld_q   <= 1'b0;
      err_len_q  <= 1'b0;
      err_sop_q  <= 1'b0;
      wr_data_q  <= '0;
      wr_port_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      port_q     <= port_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      wr_vld_q   <= accept;
      // The first beat of a grant always opens a packet at the cache.
      wr_sop_q   <= accept && first_beat;
      wr_eop_q   <= accept && eop_beat;
      err_sop_q  <= accept && first_beat && !in_sop[port_q];
      // A packet whose own eop lands exactly on the last allowed beat is
      // legal; only a watchdog-forced eop counts as a truncation.
      err_len_q  <= accept && force_eop && !in_eop[port_q];
      if (accept) begin
        wr_data_q <= port_data[port_q];
        wr_port_q <= port_q;
      end
    end
  end

  assign gnt     = gnt_q;
  assign wr_sop  = wr_sop_q;
  assign wr_eop  = wr_eop_q;
  assign wr_vld  = wr_vld_q;
  assign wr_data = wr_data_q;
  assign wr_port = wr_port_q;
  assign err_len = err_len_q;
  assign err_sop = err_sop_q;

endmodule

// File: doc/mpc_wr_arbiter.md
Name: mpc_wr_arbiter

Overview:
- Packet-granular round-robin arbiter in front of the mpcache write interface.
- Shares the single cache write path (wr_sop/wr_eop/wr_vld/wr_data) among NUM_PORTS ingress requesters.
- Holds a grant from SOP to EOP and gates new packet starts on almost_full; stalls beats on full.
- Bounds packet length with a watchdog.

Parameters:
- NUM_PORTS, 16, number of ingress requesters.
- DATA_W, 32, beat data width.
- PORT_W, 4, width of port index; equals clog2(NUM_PORTS).
- MAX_BEATS, 64, maximum beats per packet before forced termination.

Ports:
- clk_in  in  1  single clock, all logic on rising edge.
- rst_in  in  1  reset, asynchronous assert, active-high.
- req  in  NUM_PORTS  port p holds a complete packet and is ready to send.
- in_sop  in  NUM_PORTS  per-port start-of-packet qualifier.
- in_eop  in  NUM_PORTS  per-port end-of-packet qualifier.
- in_vld  in  NUM_PORTS  per-port beat valid.
- in_data  in  NUM_PORTS*DATA_W  per-port beat data; port p occupies bits [p*DATA_W +: DATA_W].
- gnt  out  NUM_PORTS  one-hot grant; the beat of the granted port is consumed when gnt[p] & in_vld[p] & !full.
- full  in  1  cache full; stalls beat acceptance.
- almost_full  in  1  cache almost full; blocks new grants only.
- wr_sop  out  1  to cache wr_sop.
- wr_eop  out  1  to cache wr_eop.
- wr_vld  out  1  to cache wr_vld.
- wr_data  out  DATA_W  to cache wr_data.
- wr_port  out  PORT_W  source port index of the current beat.
- err_len  out  1  one-cycle pulse when the watchdog truncates a packet.
- err_sop  out  1  one-cycle pulse when the first beat of a grant lacked in_sop.

Behaviour:
- Reset: all outputs 0.
  - State goes to IDLE; rr_ptr = 0; beat_cnt = 0.
  - Async assert mid-packet drops gnt immediately; the partial packet is abandoned with no wr_eop emitted.
- States:
  - IDLE: if |req && !almost_full, select the first p with req[p] set, searching from rr_ptr upward with wrap at NUM_PORTS-1 -> 0. Register gnt = onehot(p), go to XFER. Otherwise stay.
  - XFER: a beat is accepted when in_vld[p] && !full.
- Accepted beat outputs (registered, 1-cycle latency):
  - wr_vld = 1, wr_data = in_data[p], wr_port = p.
  - wr_sop = 1 on the first beat of the grant (beat_cnt == 0), forced regardless of in_sop[p].
  - If in_sop[p] was 0 on that first beat, err_sop pulses with it.
  - wr_eop = in_eop[p], or forced 1 when beat_cnt == MAX_BEATS-1; a forced eop also pulses err_len.
- Non-accepted cycles: wr_vld/wr_sop/wr_eop = 0; wr_data and wr_port hold their previous values.
- On an accepted eop beat (real or forced):
  - rr_ptr = (p+1) mod NUM_PORTS; beat_cnt = 0.
  - Re-arbitration happens in the same cycle using the updated pointer and current req/almost_full. The next gnt is registered at the next edge, giving back-to-back packets with no idle beat.
  - If no eligible requester exists, gnt = 0 and the state returns to IDLE.
- Forced truncation: after an err_len truncation, the granted port's remaining beats are not consumed by this block; upstream must flush them.
- almost_full:
  - Checked only at grant decision points.
  - Never interrupts a packet in progress.
- full:
  - Stalls acceptance; gnt stays asserted.
  - beat_cnt does not advance.
- Request drop: if req[p] drops during XFER, the grant is still held until eop; req is sampled only at arbitration.
- Simultaneous eop accept and almost_full rise: no new grant is issued; go to IDLE.
- beat_cnt: clog2(MAX_BEATS)+1 bits, saturates at no point (it is cleared on eop).
- gnt: always one-hot or zero.

Test Plan:
- Single port: req[3]=1, 4-beat packet, full=0 -> gnt=0x0008 one cycle after req; wr_vld high 4 cycles with wr_port=3; wr_sop on beat 0, wr_eop on beat 3; rr_ptr=4 afterwards.
- All 16 req high, 2-beat packets -> grant order 0,1,...,15,0; no idle cycle between packets; every wr_eop followed directly by wr_sop from port+1.
- full toggled high for 3 cycles mid-packet on port 5 -> wr_vld low for those 3 cycles; gnt stays 0x0020; beat count and data order preserved; wr_eop only on the true last beat.
- almost_full=1 with req=0x00FF, in IDLE -> gnt stays 0. Raise almost_full mid-packet on port 0 -> packet completes, then gnt=0 until almost_full drops, after which port 1 is granted.
- 70-beat packet on port 7 with MAX_BEATS=64 -> wr_eop and err_len pulse on beat 64 (beat_cnt=63); the next grant goes to the next requester. First beat with in_sop=0 -> wr_sop=1 and err_sop=1.
- rst_in asserted mid-packet on port 9 -> gnt, wr_vld and all outputs 0 asynchronously. After release with req[2]=1 -> port 2 granted (rr_ptr back to 0).
